// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes, request FSM encoding and default parameters
package traffic_pkg;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam int DB_CYCLES_DEF = 4;
    localparam int GMAX_DEF      = 32;
    localparam int HOLD_DEF      = 16;
    localparam int QW_DEF        = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVE = 2'd2, HOLDOFF = 2'd3} state_t;
    function automatic logic legal(input logic [2:0] c);
        return c == RED || c == YELLOW || c == GREEN;
    endfunction
endpackage

// File: rtl/loop_debounce.sv
// loop_debounce: 2-flop synchronizer, stable-count debouncer and rising-edge pulse
module loop_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    logic s1, s2, lvl, lvl_q;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl   <= 1'b0;
            lvl_q <= 1'b0;
            pulse <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            lvl_q <= lvl;
            pulse <= lvl & ~lvl_q;
            if (s2 == lvl) cnt <= '0;
            else if (cnt == CW'(DB_CYCLES - 1)) begin
                lvl <= s2;
                cnt <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/vehicle_request.sv
// vehicle_request: country-road queue tracking and request FSM driving x to the light controller
module vehicle_request
    import traffic_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int GMAX      = GMAX_DEF,
    parameter int HOLD      = HOLD_DEF,
    parameter int QW        = QW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          arr_raw,
    input  logic          dep_raw,
    input  logic [2:0]    highway,
    input  logic [2:0]    country,
    output logic          x,
    output logic [QW-1:0] queue_cnt,
    output logic          fault
);
    localparam int GW = $clog2(GMAX + 1);
    localparam int HW = $clog2(HOLD + 1);
    localparam logic [QW-1:0] QMAX = '1;
    logic arr_p, dep_p, bad;
    state_t state;
    logic [GW-1:0] gt;
    logic [HW-1:0] ht;

    loop_debounce #(.DB_CYCLES(DB_CYCLES)) u_arr (.clk(clk), .rst_n(rst_n), .raw(arr_raw), .pulse(arr_p));
    loop_debounce #(.DB_CYCLES(DB_CYCLES)) u_dep (.clk(clk), .rst_n(rst_n), .raw(dep_raw), .pulse(dep_p));

    assign bad = !legal(highway) || !legal(country) || (highway != RED && country != RED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            queue_cnt <= '0;
            fault     <= 1'b0;
        end else begin
            fault <= fault | bad;
            if (arr_p && !dep_p && queue_cnt != QMAX) queue_cnt <= queue_cnt + 1'b1;
            else if (dep_p && !arr_p && queue_cnt != '0) queue_cnt <= queue_cnt - 1'b1;
        end
    end

    // x is set alongside each state change so it mirrors REQ/SERVE without a decode delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            x     <= 1'b0;
            gt    <= '0;
            ht    <= '0;
        end else if (fault || bad) begin
            state <= IDLE;
            x     <= 1'b0;
            gt    <= '0;
            ht    <= '0;
        end else if (start) begin
            case (state)
                IDLE: if (queue_cnt != '0) begin
                    state <= REQ;
                    x     <= 1'b1;
                end
                REQ: if (queue_cnt == '0) begin
                    state <= IDLE;
                    x     <= 1'b0;
                end else if (country == GREEN) begin
                    state <= SERVE;
                    gt    <= '0;
                end
                SERVE: if (queue_cnt == '0) begin
                    state <= IDLE;
                    x     <= 1'b0;
                end else if (gt == GW'(GMAX - 1)) begin
                    state <= HOLDOFF;
                    x     <= 1'b0;
                    ht    <= '0;
                end else gt <= gt + 1'b1;
                HOLDOFF: if (ht == HW'(HOLD - 1)) begin
                    if (country == RED) state <= IDLE;
                end else ht <= ht + 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_vehicle_request.sv
// tb_vehicle_request: directed vectors with hand-computed expectations for vehicle_request
module tb_vehicle_request;
    logic clk = 1'b0;
    logic rst_n, start, arr_raw, dep_raw, x, fault;
    logic [2:0] highway, country;
    logic [3:0] queue_cnt;
    int errors = 0;
    int checks = 0;

    vehicle_request dut (
        .clk(clk), .rst_n(rst_n), .start(start), .arr_raw(arr_raw), .dep_raw(dep_raw),
        .highway(highway), .country(country), .x(x), .queue_cnt(queue_cnt), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic a, input logic d);
        arr_raw = a;
        dep_raw = d;
        tick(10);
        arr_raw = 1'b0;
        dep_raw = 1'b0;
        tick(10);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; arr_raw = 1'b0; dep_raw = 1'b0;
        highway = 3'b100; country = 3'b100;
        #12;
        check("rst_x", x, 0);
        check("rst_q", queue_cnt, 0);
        check("rst_fault", fault, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        // 3-cycle glitch must be rejected
        arr_raw = 1'b1;
        tick(3);
        arr_raw = 1'b0;
        tick(15);
        check("glitch_q", queue_cnt, 0);
        check("glitch_x", x, 0);
        // clean 10-cycle arrival
        arr_raw = 1'b1;
        tick(7);
        check("arr_q_early", queue_cnt, 0);
        tick(1);
        check("arr_q", queue_cnt, 1);
        check("arr_x_pre", x, 0);
        tick(1);
        check("arr_x", x, 1);
        tick(1);
        arr_raw = 1'b0;
        tick(10);
        check("arr_q_hold", queue_cnt, 1);
        // serve then empty the queue
        pulse(1'b1, 1'b0);
        check("q2", queue_cnt, 2);
        pulse(1'b0, 1'b1);
        check("dep_q1", queue_cnt, 1);
        country = 3'b001;
        tick(2);
        check("serve_x", x, 1);
        dep_raw = 1'b1;
        for (int i = 0; i < 20 && queue_cnt != 0; i++) tick(1);
        check("dep_q0", queue_cnt, 0);
        check("x_last_serve", x, 1);
        tick(1);
        check("x_empty_drop", x, 0);
        dep_raw = 1'b0;
        country = 3'b100;
        tick(10);
        // green timeout and holdoff
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
        check("q5", queue_cnt, 5);
        country = 3'b001;
        tick(32);
        check("x_green_32", x, 1);
        tick(1);
        check("x_timeout", x, 0);
        tick(7);
        check("x_holdoff_green", x, 0);
        country = 3'b100;
        tick(9);
        check("x_holdoff_end", x, 0);
        tick(1);
        check("x_rerequest", x, 1);
        // saturation and simultaneous events at QMAX
        for (int i = 0; i < 11; i++) pulse(1'b1, 1'b0);
        check("q_sat", queue_cnt, 15);
        pulse(1'b1, 1'b1);
        check("q_sat_both", queue_cnt, 15);
        // two non-red lights
        highway = 3'b001;
        country = 3'b001;
        tick(1);
        check("fault_set", fault, 1);
        check("fault_x", x, 0);
        highway = 3'b100;
        country = 3'b100;
        tick(5);
        check("fault_sticky", fault, 1);
        check("fault_x_held", x, 0);
        // reset with loop held high, start low
        start = 1'b0;
        arr_raw = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst2_fault", fault, 0);
        check("rst2_q", queue_cnt, 0);
        check("rst2_x", x, 0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("held_loop_q", queue_cnt, 1);
        check("start0_x", x, 0);
        arr_raw = 1'b0;
        tick(10);
        check("held_loop_once", queue_cnt, 1);
        start = 1'b1;
        tick(1);
        check("start1_x", x, 1);
        country = 3'b001;
        tick(3);
        check("x_serve2", x, 1);
        #2 rst_n = 1'b0;
        #1;
        check("x_async_reset", x, 0);
        tick(1);
        rst_n = 1'b1;
        country = 3'b100;
        tick(2);
        pulse(1'b0, 1'b1);
        check("dep_at_0", queue_cnt, 0);
        pulse(1'b1, 1'b1);
        check("both_at_0", queue_cnt, 0);
        // illegal code
        country = 3'b011;
        tick(1);
        check("fault_illegal", fault, 1);
        check("fault_illegal_x", x, 0);
        country = 3'b100;
        tick(3);
        check("fault_illegal_sticky", fault, 1);
        rst_n = 1'b0;
        #1;
        check("fault_cleared", fault, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
